// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
// Produces one quotient bit per cycle from operand magnitudes. The sign fixup
// is applied when the result is registered on entry to DONE, so div_hiE and
// div_loE are already valid while div_readyE is high.
module div_iter_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_startE,
   input  logic             div_signedE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             div_cancel,
   output logic             stall_divE,
   output logic             div_readyE,
   output logic [WIDTH-1:0] div_hiE,
   output logic [WIDTH-1:0] div_loE
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor)
   logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q;      // divisor magnitude
   logic             neg_quo_q;
   logic             neg_rem_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

   // Operand magnitudes and one restoring shift/trial-subtract step
   always_comb begin
      a_neg    = div_signedE & srcaE[WIDTH-1];
      b_neg    = div_signedE & srcbE[WIDTH-1];
      a_mag    = a_neg ? -srcaE : srcaE;
      b_mag    = b_neg ? -srcbE : srcbE;
      shifted  = {rem_q, quo_q[WIDTH-1]};
      trial    = shifted - {1'b0, dvs_q};
      // Borrow out of the (WIDTH+1)-bit trial means the divisor did not fit
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      quo_fix  = neg_quo_q ? -quo_next : quo_next;
      rem_fix  = neg_rem_q ? -rem_next : rem_next;
   end

   // Freeze F/D/E while a division is being accepted or iterating; a flush wins
   assign stall_divE = ~div_cancel &
                       (((state_q == StIdle) & div_startE) | (state_q == StBusy));

   // Divider FSM with registered results and ready pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         count_q    <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_readyE <= 1'b0;
         div_hiE    <= '0;
         div_loE    <= '0;
      end else if (div_cancel) begin
         state_q    <= StIdle;
         count_q    <= '0;
         div_readyE <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               div_readyE <= 1'b0;
               if (div_startE) begin
                  if (srcbE == '0) begin
                     // Divide by zero: no iteration, raw dividend as remainder
                     state_q    <= StDone;
                     div_loE    <= '1;
                     div_hiE    <= srcaE;
                     div_readyE <= 1'b1;
                  end else begin
                     state_q   <= StBusy;
                     count_q   <= '0;
                     rem_q     <= '0;
                     quo_q     <= a_mag;
                     dvs_q     <= b_mag;
                     neg_quo_q <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                  end
               end
            end
            StBusy: begin
               rem_q   <= rem_next;
               quo_q   <= quo_next;
               count_q <= count_q + 1'b1;
               if (count_q == CW'(WIDTH - 1)) begin
                  state_q    <= StDone;
                  count_q    <= '0;
                  div_loE    <= quo_fix;
                  div_hiE    <= rem_fix;
                  div_readyE <= 1'b1;
               end
            end
            StDone: begin
               // A start still asserted here belongs to the finishing DIV
               state_q    <= StIdle;
               div_readyE <= 1'b0;
            end
            default: begin
               state_q    <= StIdle;
               div_readyE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed cases plus random operands
// compared against an arithmetic reference with a fixed latency expectation.
module tb_div_iter_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         div_startE;
   logic         div_signedE;
   logic [W-1:0] srcaE;
   logic [W-1:0] srcbE;
   logic         div_cancel;
   logic         stall_divE;
   logic         div_readyE;
   logic [W-1:0] div_hiE;
   logic [W-1:0] div_loE;

   int tests = 0;
   int fails = 0;

   div_iter_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_startE (div_startE),
      .div_signedE(div_signedE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .div_cancel (div_cancel),
      .stall_divE (stall_divE),
      .div_readyE (div_readyE),
      .div_hiE    (div_hiE),
      .div_loE    (div_loE)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic, 64-bit so that MIN/-1 wraps naturally
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, output logic [W-1:0] q,
                                   output logic [W-1:0] r);
      longint sa, sb, lq, lr;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[W-1:0];
         r  = lr[W-1:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Advance to just after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds start for the whole instruction lifetime, including the DONE cycle
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input string tag);
      logic [W-1:0] eq, er;
      int lat;
      ref_div(a, b, sgn, eq, er);
      lat = (b == 0) ? 1 : W + 1;
      for (int k = 0; k <= lat; k++) begin
         div_startE  = 1'b1;
         div_signedE = sgn;
         srcaE       = a;
         srcbE       = b;
         div_cancel  = 1'b0;
         #1;
         if (k == 0 || k == lat - 1) begin
            check({tag, " stall"}, 32'(stall_divE), 32'd1);
            check({tag, " ready_lo"}, 32'(div_readyE), 32'd0);
         end else if (k == lat) begin
            check({tag, " stall_done"}, 32'(stall_divE), 32'd0);
            check({tag, " ready"}, 32'(div_readyE), 32'd1);
            check({tag, " lo"}, div_loE, eq);
            check({tag, " hi"}, div_hiE, er);
         end else if (stall_divE !== 1'b1 || div_readyE !== 1'b0) begin
            check({tag, " mid_stall"}, 32'(stall_divE), 32'd1);
            check({tag, " mid_ready"}, 32'(div_readyE), 32'd0);
         end
         next_cycle();
      end
   endtask

   initial begin
      logic [W-1:0] a, b, prev_hi, prev_lo;
      logic sgn, saw_ready;

      rst = 1'b1; div_startE = 1'b0; div_signedE = 1'b0;
      srcaE = '0; srcbE = '0; div_cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset ready", 32'(div_readyE), 32'd0);
      check("reset stall", 32'(stall_divE), 32'd0);
      check("reset hi", div_hiE, 32'd0);
      check("reset lo", div_loE, 32'd0);
      next_cycle();

      run_div(32'd7, 32'd2, 1'b0, "divu_7_2");
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_ovf_ops");
      run_div(32'd5, 32'd0, 1'b0, "divu_5_0");
      run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "div_neg_0");
      run_div(32'd5, 32'd0, 1'b0, "divu_5_0_again");
      div_startE = 1'b0;
      next_cycle();

      // Cancel during BUSY at t10: no pulse, results keep the prior values
      prev_hi = 32'd5;
      prev_lo = 32'hFFFF_FFFF;
      for (int k = 0; k <= 10; k++) begin
         div_startE = 1'b1; div_signedE = 1'b0;
         srcaE = 32'd1000; srcbE = 32'd3; div_cancel = (k == 10);
         #1;
         if (k == 10) begin
            check("cancel stall", 32'(stall_divE), 32'd0);
            check("cancel ready", 32'(div_readyE), 32'd0);
         end
         next_cycle();
      end
      div_startE = 1'b0; div_cancel = 1'b0;
      #1;
      check("cancel idle stall", 32'(stall_divE), 32'd0);
      check("cancel hi", div_hiE, prev_hi);
      check("cancel lo", div_loE, prev_lo);
      saw_ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
         next_cycle();
         if (div_readyE !== 1'b0) saw_ready = 1'b1;
      end
      check("cancel no pulse", 32'(saw_ready), 32'd0);
      check("cancel hi held", div_hiE, prev_hi);

      // Synchronous reset at BUSY t20 discards the operation
      for (int k = 0; k <= 20; k++) begin
         div_startE = 1'b1; div_signedE = 1'b1;
         srcaE = 32'd12345; srcbE = 32'd17; rst = (k == 20);
         next_cycle();
      end
      rst = 1'b0; div_startE = 1'b0;
      #1;
      check("rst stall", 32'(stall_divE), 32'd0);
      check("rst ready", 32'(div_readyE), 32'd0);
      check("rst hi", div_hiE, 32'd0);
      check("rst lo", div_loE, 32'd0);
      next_cycle();

      // Back-to-back: second begins the cycle after DONE
      run_div(32'd100, 32'd7, 1'b0, "b2b_100_7");
      run_div(32'd9, 32'd3, 1'b0, "b2b_9_3");

      for (int i = 0; i < 24; i++) begin
         a   = $urandom;
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_div(a, b, sgn, $sformatf("rand%0d", i));
      end
      div_startE = 1'b0;
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
